// File: rtl/usb_crc_pkg.sv
// USB CRC16 constants and checker state encoding shared by the rx CRC logic.
// No timing or flow control of its own; pure definitions.
package usb_crc_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } crc_chk_state_t;

endpackage

// File: rtl/crc16_rx_lfsr.sv
// Serial USB CRC16 register: one bit per shift_en, load_init restarts at 0xFFFF.
// Updates on the next edge; no backpressure, the caller gates shift_en.
module crc16_rx_lfsr
  import usb_crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_init,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = din ^ crc_q[15];
    if (load_init) begin
      crc_d = CRC16_INIT;
    end else if (shift_en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc16_checker.sv
// Receive-side USB CRC16 checker; result pulses two cycles after the rx_eop cycle.
// Accepts one bit per clock with no backpressure; rx_sop always restarts the check.
module crc16_checker
  import usb_crc_pkg::*;
#(
  parameter int MAX_BYTES = 1027,
  parameter int BC_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_sop,
  input  logic            rx_bit,
  input  logic            rx_bit_valid,
  input  logic            rx_eop,
  output logic            crc_busy,
  output logic            crc_done,
  output logic            crc_ok,
  output logic            crc_err,
  output logic            err_align,
  output logic            err_short,
  output logic [BC_W-1:0] byte_count,
  output logic [15:0]     crc_value
);

  crc_chk_state_t  state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0] byte_count_q, byte_count_d;
  logic            done_q, done_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            align_q, align_d;
  logic            short_q, short_d;
  logic            shift_en;
  logic [15:0]     crc;

  // rx_sop discards any bit presented alongside it.
  assign shift_en = (state_q == ACCUM) && rx_bit_valid && !rx_sop;

  crc16_rx_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_init (rx_sop),
    .shift_en  (shift_en),
    .din       (rx_bit),
    .crc       (crc)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_count_d = byte_count_q;
    done_d       = 1'b0;
    ok_d         = ok_q;
    err_d        = err_q;
    align_d      = align_q;
    short_d      = short_q;

    if (rx_sop) begin
      state_d      = ACCUM;
      bit_cnt_d    = 3'd0;
      byte_count_d = '0;
      ok_d         = 1'b0;
      err_d        = 1'b0;
      align_d      = 1'b0;
      short_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ACCUM: begin
          if (rx_bit_valid) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && byte_count_q != BC_W'(MAX_BYTES)) begin
              byte_count_d = byte_count_q + BC_W'(1);
            end
          end
          if (rx_eop) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          state_d = DONE;
          done_d  = 1'b1;
          align_d = (bit_cnt_q != 3'd0);
          short_d = (byte_count_q < BC_W'(2));
          ok_d    = (bit_cnt_q == 3'd0) && (byte_count_q >= BC_W'(2))
                    && (crc == CRC16_RESIDUE);
          err_d   = !ok_d;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      align_q      <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      align_q      <= align_d;
      short_q      <= short_d;
    end
  end

  assign crc_busy   = (state_q == ACCUM) || (state_q == CHECK);
  assign crc_done   = done_q;
  assign crc_ok     = ok_q;
  assign crc_err    = err_q;
  assign err_align  = align_q;
  assign err_short  = short_q;
  assign byte_count = byte_count_q;
  assign crc_value  = crc;

endmodule

// File: tb/tb_crc16_checker.sv
// Directed bench for crc16_checker: known-good USB CRC packets, corrupted and
// truncated packets, sop/rst aborts and stray inputs while idle.
module tb_crc16_checker;

  localparam int BC_W = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_sop;
  logic            rx_bit;
  logic            rx_bit_valid;
  logic            rx_eop;
  logic            crc_busy;
  logic            crc_done;
  logic            crc_ok;
  logic            crc_err;
  logic            err_align;
  logic            err_short;
  logic [BC_W-1:0] byte_count;
  logic [15:0]     crc_value;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  crc16_checker dut (
    .clk          (clk),
    .rst          (rst),
    .rx_sop       (rx_sop),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .rx_eop       (rx_eop),
    .crc_busy     (crc_busy),
    .crc_done     (crc_done),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .err_align    (err_align),
    .err_short    (err_short),
    .byte_count   (byte_count),
    .crc_value    (crc_value)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_sop       = 1'b0;
    rx_bit       = 1'b0;
    rx_bit_valid = 1'b0;
    rx_eop       = 1'b0;
  endtask

  // sop, n bits LSB-first from bits, eop (with last bit or one cycle later),
  // then the CHECK cycle; returns in the first DONE cycle.
  task automatic send_pkt(input logic [31:0] bits, input int n, input bit eop_with_last);
    rx_sop = 1'b1;
    tick();
    rx_sop = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit       = bits[i];
      rx_eop       = eop_with_last && (i == n - 1);
      tick();
    end
    idle_inputs();
    if (!eop_with_last) begin
      rx_eop = 1'b1;
      tick();
      rx_eop = 1'b0;
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_crc", crc_value, 32'hFFFF);
    chk("rst_busy", crc_busy, 0);
    chk("rst_done", crc_done, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_err", crc_err, 0);
    chk("rst_bc", byte_count, 0);
    rst = 1'b0;
    tick();

    // Stray bits and eop while idle
    rx_bit_valid = 1'b1;
    rx_bit       = 1'b1;
    tick();
    rx_bit_valid = 1'b0;
    rx_eop       = 1'b1;
    tick();
    rx_eop = 1'b0;
    chk("idle_crc", crc_value, 32'hFFFF);
    chk("idle_busy", crc_busy, 0);
    tick();
    chk("idle_done", crc_done, 0);
    chk("idle_bc", byte_count, 0);

    // Zero-length DATA packet, stepped by hand to check latency
    rx_sop = 1'b1;
    tick();
    rx_sop = 1'b0;
    chk("sop_busy", crc_busy, 1);
    chk("sop_crc", crc_value, 32'hFFFF);
    for (int i = 0; i < 16; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit       = 1'b0;
      tick();
    end
    idle_inputs();
    chk("z_crc", crc_value, 32'h800D);
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
    chk("z_check_done", crc_done, 0);
    chk("z_check_busy", crc_busy, 1);
    tick();
    chk("z_done", crc_done, 1);
    chk("z_ok", crc_ok, 1);
    chk("z_err", crc_err, 0);
    chk("z_bc", byte_count, 2);
    chk("z_busy", crc_busy, 0);
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
    chk("z_done_pulse", crc_done, 0);
    chk("z_ok_hold", crc_ok, 1);
    tick();
    chk("z_eop_in_done", crc_done, 0);

    // Bit 3 corrupted
    send_pkt(32'h0000_0008, 16, 1'b0);
    chk("flip_done", crc_done, 1);
    chk("flip_ok", crc_ok, 0);
    chk("flip_err", crc_err, 1);
    chk("flip_align", err_align, 0);
    chk("flip_short", err_short, 0);

    // 15 bits: misaligned
    send_pkt(32'h0, 15, 1'b0);
    chk("b15_err", crc_err, 1);
    chk("b15_ok", crc_ok, 0);
    chk("b15_align", err_align, 1);
    chk("b15_bc", byte_count, 1);

    // Single byte: short
    send_pkt(32'h0, 8, 1'b0);
    chk("b8_err", crc_err, 1);
    chk("b8_short", err_short, 1);
    chk("b8_align", err_align, 0);
    chk("b8_bc", byte_count, 1);

    // eop on the last bit
    send_pkt(32'h0, 16, 1'b1);
    chk("same_done", crc_done, 1);
    chk("same_ok", crc_ok, 1);
    chk("same_crc", crc_value, 32'h800D);

    // sop in DONE clears results
    rx_sop = 1'b1;
    tick();
    rx_sop = 1'b0;
    chk("resop_ok", crc_ok, 0);
    chk("resop_crc", crc_value, 32'hFFFF);

    // 9 bits of garbage then restart mid-packet
    for (int i = 0; i < 9; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit       = 1'b1;
      tick();
    end
    idle_inputs();
    chk("mid_bc", byte_count, 1);
    send_pkt(32'h0, 16, 1'b0);
    chk("mid_ok", crc_ok, 1);
    chk("mid_bc2", byte_count, 2);

    // rst mid-packet
    rx_sop = 1'b1;
    tick();
    rx_sop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit       = 1'b1;
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_crc", crc_value, 32'hFFFF);
    chk("mrst_busy", crc_busy, 0);
    chk("mrst_ok", crc_ok, 0);
    chk("mrst_err", crc_err, 0);
    chk("mrst_bc", byte_count, 0);
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
    tick();
    chk("mrst_no_done", crc_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
